// File: rtl/lsu_arb.sv
// ----------------------------------------------------------------------------
// lsu_arb : two-master LSU arbiter, IDLE->ISSUE->RESP, RR/fixed priority + lock
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module lsu_arb #(
  parameter int RR_EN    = 1,
  parameter int LOCK_MAX = 4
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_m0_req,
  input  logic        i_m0_lock,
  input  logic [31:0] i_m0_addr,
  input  logic [31:0] i_m0_wdata,
  input  logic [3:0]  i_m0_bmask,
  input  logic        i_m0_wren,
  output logic        o_m0_ack,
  output logic [31:0] o_m0_rdata,
  input  logic        i_m1_req,
  input  logic        i_m1_lock,
  input  logic [31:0] i_m1_addr,
  input  logic [31:0] i_m1_wdata,
  input  logic [3:0]  i_m1_bmask,
  input  logic        i_m1_wren,
  output logic        o_m1_ack,
  output logic [31:0] o_m1_rdata,
  output logic [31:0] o_lsu_addr,
  output logic [31:0] o_lsu_wdata,
  output logic [3:0]  o_lsu_bmask,
  output logic        o_lsu_wren,
  input  logic [31:0] i_lsu_rdata,
  output logic        o_busy,
  output logic        o_gnt_id
);

  localparam logic [3:0] C_LOCK_MAX = 4'(LOCK_MAX);
  localparam logic       C_RR_EN    = (RR_EN != 0);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_RESP  = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic        gnt_q, gnt_d;
  logic        lock_q, lock_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        justack_q;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  bmask_q, bmask_d;
  logic        wren_q, wren_d;
  logic [31:0] rdata0_q, rdata1_q;

  logic [1:0]  w_req_raw;
  logic [1:0]  w_mask;
  logic [1:0]  w_req_v;
  logic        w_lock_pend;
  logic        w_grant;
  logic        w_win;
  logic        w_win_lock;

  assign w_req_raw   = {i_m1_req, i_m0_req};
  // The requester acked last cycle is not eligible in the following IDLE cycle.
  assign w_mask      = justack_q ? (gnt_q ? 2'b10 : 2'b01) : 2'b00;
  assign w_req_v     = w_req_raw & ~w_mask;
  assign w_lock_pend = lock_q && (cnt_q != C_LOCK_MAX);
  assign w_win_lock  = w_win ? i_m1_lock : i_m0_lock;

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    lock_d  = lock_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    bmask_d = bmask_q;
    wren_d  = wren_q;
    w_grant = 1'b0;
    w_win   = 1'b0;
    case (state_q)
      S_IDLE: begin
        // A pending lock holds arbitration through the masked cycle so the
        // other requester cannot slip in between locked transactions.
        if (justack_q && w_lock_pend) begin
          w_grant = 1'b0;
        end else if (w_lock_pend && w_req_raw[gnt_q]) begin
          w_grant = 1'b1;
          w_win   = gnt_q;
        end else if (w_req_v != 2'b00) begin
          w_grant = 1'b1;
          if (w_req_v == 2'b11) w_win = C_RR_EN ? ~gnt_q : 1'b0;
          else                  w_win = w_req_v[1];
        end
        if (w_grant) begin
          state_d = S_ISSUE;
          gnt_d   = w_win;
          lock_d  = w_win_lock;
          addr_d  = w_win ? i_m1_addr  : i_m0_addr;
          wdata_d = w_win ? i_m1_wdata : i_m0_wdata;
          bmask_d = w_win ? i_m1_bmask : i_m0_bmask;
          wren_d  = w_win ? i_m1_wren  : i_m0_wren;
          if (!w_win_lock)                                cnt_d = 4'd0;
          else if (w_win == gnt_q && cnt_q != C_LOCK_MAX) cnt_d = cnt_q + 4'd1;
          else                                            cnt_d = 4'd1;
        end
      end
      S_ISSUE: state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q   <= S_IDLE;
      gnt_q     <= 1'b0;
      lock_q    <= 1'b0;
      cnt_q     <= 4'd0;
      justack_q <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      bmask_q   <= '0;
      wren_q    <= 1'b0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      lock_q    <= lock_d;
      cnt_q     <= cnt_d;
      justack_q <= (state_q == S_RESP);
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      bmask_q   <= bmask_d;
      wren_q    <= wren_d;
      if (state_q == S_ISSUE && !wren_q) begin
        if (gnt_q) rdata1_q <= i_lsu_rdata;
        else       rdata0_q <= i_lsu_rdata;
      end
    end
  end

  logic w_issue;
  assign w_issue     = (state_q == S_ISSUE);
  assign o_lsu_addr  = w_issue ? addr_q  : 32'd0;
  assign o_lsu_wdata = w_issue ? wdata_q : 32'd0;
  assign o_lsu_bmask = w_issue ? bmask_q : 4'd0;
  assign o_lsu_wren  = w_issue && wren_q;
  assign o_m0_ack    = (state_q == S_RESP) && !gnt_q;
  assign o_m1_ack    = (state_q == S_RESP) && gnt_q;
  assign o_m0_rdata  = rdata0_q;
  assign o_m1_rdata  = rdata1_q;
  assign o_busy      = (state_q != S_IDLE);
  assign o_gnt_id    = gnt_q;

endmodule

`default_nettype wire

// File: tb/tb_lsu_arb.sv
// ----------------------------------------------------------------------------
// tb_lsu_arb : directed bench, round-robin instance plus fixed-priority twin
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_lsu_arb;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        m0_req = 0, m0_lock = 0, m0_wren = 0;
  logic        m1_req = 0, m1_lock = 0, m1_wren = 0;
  logic [31:0] m0_addr = 0, m0_wdata = 0, m1_addr = 0, m1_wdata = 0;
  logic [3:0]  m0_bmask = 0, m1_bmask = 0;
  logic [31:0] lsu_rdata = 0;

  logic        ack0, ack1, wren, busy, gnt;
  logic [31:0] rd0, rd1, laddr, lwdata;
  logic [3:0]  lbmask;
  logic        f_ack0, f_ack1, f_wren, f_busy, f_gnt;
  logic [31:0] f_rd0, f_rd1, f_laddr, f_lwdata;
  logic [3:0]  f_lbmask;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  lsu_arb #(.RR_EN(1), .LOCK_MAX(4)) u_rr (
    .i_clk(clk), .i_reset_n(rst_n),
    .i_m0_req(m0_req), .i_m0_lock(m0_lock), .i_m0_addr(m0_addr), .i_m0_wdata(m0_wdata),
    .i_m0_bmask(m0_bmask), .i_m0_wren(m0_wren), .o_m0_ack(ack0), .o_m0_rdata(rd0),
    .i_m1_req(m1_req), .i_m1_lock(m1_lock), .i_m1_addr(m1_addr), .i_m1_wdata(m1_wdata),
    .i_m1_bmask(m1_bmask), .i_m1_wren(m1_wren), .o_m1_ack(ack1), .o_m1_rdata(rd1),
    .o_lsu_addr(laddr), .o_lsu_wdata(lwdata), .o_lsu_bmask(lbmask), .o_lsu_wren(wren),
    .i_lsu_rdata(lsu_rdata), .o_busy(busy), .o_gnt_id(gnt)
  );

  lsu_arb #(.RR_EN(0), .LOCK_MAX(4)) u_fp (
    .i_clk(clk), .i_reset_n(rst_n),
    .i_m0_req(m0_req), .i_m0_lock(m0_lock), .i_m0_addr(m0_addr), .i_m0_wdata(m0_wdata),
    .i_m0_bmask(m0_bmask), .i_m0_wren(m0_wren), .o_m0_ack(f_ack0), .o_m0_rdata(f_rd0),
    .i_m1_req(m1_req), .i_m1_lock(m1_lock), .i_m1_addr(m1_addr), .i_m1_wdata(m1_wdata),
    .i_m1_bmask(m1_bmask), .i_m1_wren(m1_wren), .o_m1_ack(f_ack1), .o_m1_rdata(f_rd1),
    .o_lsu_addr(f_laddr), .o_lsu_wdata(f_lwdata), .o_lsu_bmask(f_lbmask), .o_lsu_wren(f_wren),
    .i_lsu_rdata(lsu_rdata), .o_busy(f_busy), .o_gnt_id(f_gnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin : main
    int wcnt;
    int ack_at;
    int ng;
    logic prev_busy;
    logic [31:0] g [0:4];

    // reset state
    #3;
    chk("rst_busy", busy, 0);
    chk("rst_wren", wren, 0);
    chk("rst_gnt", gnt, 0);
    chk("rst_rd0", rd0, 0);
    chk("rst_ack0", ack0, 0);
    tick();
    rst_n = 1'b1;

    // single load by m0
    lsu_rdata = 32'hDEADBEEF;
    m0_addr = 32'h10; m0_wren = 0; m0_bmask = 4'hF; m0_req = 1;
    chk("ld_c1_addr", laddr, 0);
    chk("ld_c1_busy", busy, 0);
    tick();
    chk("ld_c2_addr", laddr, 32'h10);
    chk("ld_c2_wren", wren, 0);
    chk("ld_c2_ack", ack0, 0);
    tick();
    chk("ld_c3_ack", ack0, 1);
    chk("ld_c3_rdata", rd0, 32'hDEADBEEF);
    chk("ld_c3_addr", laddr, 0);
    m0_req = 0;
    tick();
    chk("ld_c4_ack", ack0, 0);
    chk("ld_c4_busy", busy, 0);

    // single store by m1
    m1_addr = 32'h1000_0000; m1_wdata = 32'hFF; m1_wren = 1; m1_bmask = 4'h3; m1_req = 1;
    wcnt = 0; ack_at = -1;
    for (int i = 0; i < 5; i++) begin
      if (wren) begin
        wcnt++;
        chk("st_addr", laddr, 32'h1000_0000);
        chk("st_wdata", lwdata, 32'hFF);
        chk("st_bmask", {28'd0, lbmask}, 32'h3);
      end
      if (ack1) begin
        ack_at = i;
        m1_req = 0;
      end
      tick();
    end
    chk("st_wren_cycles", wcnt, 1);
    chk("st_ack_cycle", ack_at, 2);
    chk("st_rd1_kept", rd1, 0);
    chk("st_gnt", gnt, 1);

    // contention: both loads held high, last grant was m1
    m0_wren = 0; m1_wren = 0; m0_req = 1; m1_req = 1;
    for (int i = 1; i <= 11; i++) begin
      tick();
      if (i % 3 == 1) begin
        chk("rr_gnt", gnt, ((i / 3) % 2 == 0) ? 32'd0 : 32'd1);
        chk("fp_gnt", f_gnt, ((i / 3) % 2 == 0) ? 32'd0 : 32'd1);
      end
      if (i % 3 == 2) chk("rr_ack_who", {30'd0, ack1, ack0}, ((i / 3) % 2 == 0) ? 32'd1 : 32'd2);
    end
    m0_req = 0; m1_req = 0;
    tick();
    tick();

    // lone m0 load makes m0 "last" in both instances
    lsu_rdata = 32'h1234_5678;
    m0_addr = 32'h20; m0_req = 1;
    tick();
    chk("lone_gnt_rr", gnt, 0);
    chk("lone_gnt_fp", f_gnt, 0);
    tick();
    chk("lone_rdata", rd0, 32'h1234_5678);
    m0_req = 0;
    tick();
    tick();

    // tie of stores: RR picks m1, fixed priority picks m0; then reset in ISSUE
    m0_wren = 1; m1_wren = 1; m1_addr = 32'h0000_0040; m0_req = 1; m1_req = 1;
    tick();
    chk("tie_gnt_rr", gnt, 1);
    chk("tie_gnt_fp", f_gnt, 0);
    chk("tie_wren", wren, 1);
    chk("tie_addr", laddr, 32'h40);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mrst_wren", wren, 0);
    chk("mrst_fwren", f_wren, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_gnt", gnt, 0);
    chk("mrst_rd0", rd0, 0);
    chk("mrst_addr", laddr, 0);
    m0_req = 0; m1_req = 0; m0_wren = 0; m1_wren = 0;
    tick();
    chk("mrst_ack", {30'd0, ack1, ack0}, 0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_busy", busy, 0);

    // lock cap: m0 locks continuously, m1 joins
    m0_lock = 1; m0_addr = 32'h80; m0_req = 1;
    ng = 0; prev_busy = 0;
    for (int c = 0; c < 60 && ng < 5; c++) begin
      tick();
      if (busy && !prev_busy) begin
        g[ng] = {31'd0, gnt};
        ng++;
        if (ng == 1) m1_req = 1;
        if (ng == 5) chk("lock_fp_5th", f_gnt, 1);
      end
      prev_busy = busy;
    end
    chk("lock_ngrants", ng, 5);
    if (ng == 5) begin
      for (int k = 0; k < 5; k++) chk("lock_gnt", g[k], (k < 4) ? 32'd0 : 32'd1);
    end
    m0_req = 0; m0_lock = 0;
    ack_at = -1;
    for (int c = 0; c < 6 && ack_at < 0; c++) begin
      if (ack1) ack_at = c;
      else tick();
    end
    chk("lock_m1_ack_seen", (ack_at >= 0) ? 32'd1 : 32'd0, 1);
    m1_req = 0;
    tick();
    tick();

    // idle hold
    for (int i = 0; i < 10; i++) begin
      chk("idle_busy", busy, 0);
      chk("idle_wren", wren, 0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

`default_nettype wire
